led_seq_ctrl: RTL and testbench

- Sequencer that owns a bank of blink LEDs and drives them one at a time: LED 0 blinks N times, then LED 1, and so on up to the last LED.
- After the last LED the block either stops or wraps back to LED 0.
- A shared prescaler generates the half-period tick for the whole bank.
- Sits between the board LED pins and a simple start/abort control source (button logic or a host register).

---
 rtl/led_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_led_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_ctrl
//  Purpose  : Blink sequencer for a bank of LEDs. LED 0 blinks N full times,
//             then LED 1, ... up to the last LED; afterwards the sequence
//             either stops (one-cycle done pulse) or wraps back to LED 0.
//             One shared prescaler produces the half-period tick.
//  Ports    : clk          - system clock, rising edge
//             rst_n        - asynchronous active-low reset
//             start        - single-cycle start request, honoured only in IDLE
//             abort        - synchronous stop, forces IDLE
//             blink_count  - full blinks per LED (0 behaves as 1), latched
//                            on the accepted start
//             loop_en      - wrap to LED 0 after the last LED
//             led          - active-high LED drive
//             active_idx   - index of the LED being sequenced (0 outside RUN)
//             busy         - high while running
//             done         - one-cycle pulse at the end of a non-looping run
//  Revision : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
  parameter int NUM_LEDS = 4,
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CNT_W-1:0]            blink_count,
  input  logic                        loop_en,
  output logic [NUM_LEDS-1:0]         led,
  output logic [$clog2(NUM_LEDS)-1:0] active_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int IDX_W = $clog2(NUM_LEDS);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [PRE_W-1:0]   prescaler;
  logic [CNT_W:0]     toggle_cnt;
  logic [CNT_W-1:0]   n_lat;
  logic [IDX_W-1:0]   idx;

  logic               tick;
  logic [CNT_W:0]     toggle_next;
  logic               seg_end;
  logic               last_led;
  logic [NUM_LEDS-1:0] led_flip;

  assign tick        = (prescaler == PRE_W'(TICK_DIV - 1));
  assign toggle_next = toggle_cnt + {{CNT_W{1'b0}}, 1'b1};
  // 2*N toggles complete one LED: it has blinked N times and ended low.
  assign seg_end     = (toggle_next == {n_lat, 1'b0});
  assign last_led    = (idx == IDX_W'(NUM_LEDS - 1));
  // Only led[idx] can be non-zero, so flipping that bit is the whole update.
  assign led_flip    = led ^ (NUM_LEDS'(1) << idx);

  assign active_idx  = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      prescaler  <= '0;
      toggle_cnt <= '0;
      n_lat      <= '0;
      idx        <= '0;
      led        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      prescaler  <= '0;
      toggle_cnt <= '0;
      idx        <= '0;
      led        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done      <= 1'b0;
          led       <= '0;
          prescaler <= '0;
          if (start) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            n_lat      <= (blink_count == '0) ? CNT_W'(1) : blink_count;
            idx        <= '0;
            toggle_cnt <= '0;
          end
        end

        S_RUN: begin
          if (tick) begin
            prescaler <= '0;
            led       <= led_flip;
            if (seg_end) begin
              toggle_cnt <= '0;
              if (!last_led) begin
                idx <= idx + IDX_W'(1);
              end else if (loop_en) begin
                idx <= '0;
              end else begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                idx   <= '0;
                led   <= '0;
              end
            end else begin
              toggle_cnt <= toggle_next;
            end
          end else begin
            prescaler <= prescaler + PRE_W'(1);
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here.
          done  <= 1'b0;
          led   <= '0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          led   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_seq_ctrl
//  Purpose  : Self-checking bench for led_seq_ctrl (NUM_LEDS=4, TICK_DIV=4).
//             A timeline model derives LED state from the number of cycles
//             elapsed since the current pass began.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

  localparam int NL = 4;
  localparam int TD = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          loop_en = 1'b0;
  logic [CW-1:0] blink_count = '0;
  logic [NL-1:0] led;
  logic [1:0]    active_idx;
  logic          busy;
  logic          done;

  led_seq_ctrl #(.NUM_LEDS(NL), .TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .blink_count(blink_count), .loop_en(loop_en),
    .led(led), .active_idx(active_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: running flag, cycles since pass start, latched N.
  bit m_run;
  bit m_done;
  int m_t;
  int m_n;

  function automatic void model_reset();
    m_run = 0; m_done = 0; m_t = 0; m_n = 1;
  endfunction

  function automatic void model_step(bit s, bit a, bit l, int bc);
    if (a) begin
      m_run = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (s) begin
        m_run = 1; m_t = 0; m_n = (bc == 0) ? 1 : bc;
      end
    end else begin
      m_t++;
      if (m_t == NL * 2 * m_n * TD) begin
        if (l) m_t = 0;
        else begin
          m_run = 0; m_done = 1;
        end
      end
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    int k;
    int e_idx;
    logic [NL-1:0] e_led;
    e_led = '0;
    e_idx = 0;
    if (m_run) begin
      k = m_t / TD;                  // ticks seen in this pass
      e_idx = k / (2 * m_n);
      if (k % 2 == 1) e_led = NL'(1) << e_idx;
    end
    chk("led", 32'(led), 32'(e_led));
    chk("active_idx", 32'(active_idx), 32'(e_idx));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("onehot", 32'($countones(led) <= 1), 32'd1);
  endtask

  task automatic tick();
    bit s, a, l;
    int b;
    s = start; a = abort; l = loop_en; b = int'(blink_count);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(s, a, l, b);
    #1;
    check_all();
  endtask

  // Counts edges after the accept edge until done is seen (bounded).
  task automatic wait_done(int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      tick();
      cyc++;
      if (done === 1'b1) break;
    end
    if (done !== 1'b1) begin
      chk("done_timeout", 32'(cyc), 32'(limit + 1));
    end
  endtask

  initial begin
    int cyc;
    int n;
    checks = 0;
    errors = 0;
    model_reset();

    // Reset values
    #1;
    check_all();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic run, N=2: done 64 edges after accept
    blink_count = 4'd2; start = 1'b1; tick(); start = 1'b0;
    wait_done(200, cyc);
    chk("len_bc2", 32'(cyc), 32'd64);
    tick();

    // N=0 treated as 1: 32 edges
    blink_count = 4'd0; start = 1'b1; tick(); start = 1'b0;
    wait_done(200, cyc);
    chk("len_bc0", 32'(cyc), 32'd32);
    tick();

    // Looping with N=1, then stop at the next wrap
    loop_en = 1'b1; blink_count = 4'd1; start = 1'b1; tick(); start = 1'b0;
    repeat (32) tick();
    chk("loop_idx0", 32'(active_idx), 32'd0);
    chk("loop_busy", 32'(busy), 32'd1);
    repeat (4) tick();
    chk("loop_led0_rise", 32'(led), 32'd1);
    loop_en = 1'b0;
    wait_done(200, cyc);
    chk("loop_stop_len", 32'(cyc), 32'd28);
    tick();

    // Abort while led[2] is lit, restart one cycle later
    blink_count = 4'd2; start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (led !== 4'b0100 && n < 200) begin
      tick();
      n++;
    end
    chk("reach_led2", 32'(led), 32'h4);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_led", 32'(led), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    tick();
    chk("abort_nodone", 32'(done), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    chk("restart_led_low", 32'(led), 32'd0);
    tick();
    chk("restart_led_rise", 32'(led), 32'd1);
    wait_done(200, cyc);
    chk("restart_len", 32'(cyc), 32'd60);
    tick();

    // start held high through RUN and the DONE cycle
    blink_count = 4'd2; start = 1'b1; tick();
    wait_done(200, cyc);
    chk("hold_start_len", 32'(cyc), 32'd64);
    tick();
    chk("done_start_ignored", 32'(busy), 32'd0);
    start = 1'b0;
    tick();

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);
    tick();

    // Asynchronous reset between edges mid-run
    blink_count = 4'd3; start = 1'b1; tick(); start = 1'b0;
    repeat (13) tick();
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("post_reset_idle", 32'(busy), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start       = ($urandom_range(0, 7) == 0);
      abort       = ($urandom_range(0, 99) == 0);
      loop_en     = ($urandom_range(0, 2) == 0);
      blink_count = CW'($urandom_range(0, 3));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
